// File: rtl/dmux16_stream.sv
// ----------------------------------------------------------------------------
// dmux16_stream
//
// 1-to-2 stream demultiplexer for `width`-bit words (inverse of mux16_bit).
// Each accepted input word is steered to channel 0 or channel 1 according to
// `s`. Each channel owns a one-deep registered holding stage with its own
// valid/ready handshake, so the two consumers drain independently.
//
// Ports:
//   clk         in   system clock, rising-edge active
//   reset       in   asynchronous active-high reset, clears all state
//   in          in   [width] data word from the producer
//   in_valid    in   producer has a word on `in`
//   in_ready    out  selected channel can take a word (combinational)
//   s           in   channel select, 0 -> out0, 1 -> out1 (sampled on accept)
//   out0        out  [width] registered data, channel 0
//   out0_valid  out  channel 0 holds a word
//   out0_ready  in   consumer 0 takes the word
//   out1        out  [width] registered data, channel 1
//   out1_valid  out  channel 1 holds a word
//   out1_ready  in   consumer 1 takes the word
//
// Optional feature, enabled by defining DMUX16_COUNT_EN:
//   count0      out  [16] words accepted into channel 0 (wrapping)
//   count1      out  [16] words accepted into channel 1 (wrapping)
// ----------------------------------------------------------------------------
module dmux16_stream #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s,
    output logic [width-1:0] out0,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [width-1:0] out1,
    output logic             out1_valid,
    input  logic             out1_ready
`ifdef DMUX16_COUNT_EN
    ,
    output logic [15:0]      count0,
    output logic [15:0]      count1
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    ch_state_t state0, state0_next;
    ch_state_t state1, state1_next;

    logic accept;
    logic accept0;
    logic accept1;

    // ------------------------------------------------------------------
    // Readiness and accept decode
    // ------------------------------------------------------------------
    // A channel can take a word when it is empty or is being drained in
    // this same cycle, which is what gives back-to-back throughput.
    always_comb begin
        in_ready = 1'b0;
        if (s) begin
            in_ready = ~out1_valid | out1_ready;
        end else begin
            in_ready = ~out0_valid | out0_ready;
        end
    end

    always_comb begin
        accept  = in_valid & in_ready;
        accept0 = accept & ~s;
        accept1 = accept &  s;
    end

    // ------------------------------------------------------------------
    // Channel 0 state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state0 <= EMPTY;
        end else begin
            state0 <= state0_next;
        end
    end

    always_comb begin
        state0_next = state0;
        unique case (state0)
            EMPTY: begin
                if (accept0) begin
                    state0_next = FULL;
                end
            end
            FULL: begin
                // A new word arriving while the old one drains keeps us FULL.
                if (accept0) begin
                    state0_next = FULL;
                end else if (out0_ready) begin
                    state0_next = EMPTY;
                end
            end
            default: state0_next = EMPTY;
        endcase
    end

    always_comb begin
        out0_valid = (state0 == FULL);
    end

    // ------------------------------------------------------------------
    // Channel 1 state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state1 <= EMPTY;
        end else begin
            state1 <= state1_next;
        end
    end

    always_comb begin
        state1_next = state1;
        unique case (state1)
            EMPTY: begin
                if (accept1) begin
                    state1_next = FULL;
                end
            end
            FULL: begin
                if (accept1) begin
                    state1_next = FULL;
                end else if (out1_ready) begin
                    state1_next = EMPTY;
                end
            end
            default: state1_next = EMPTY;
        endcase
    end

    always_comb begin
        out1_valid = (state1 == FULL);
    end

    // ------------------------------------------------------------------
    // Data registers: load only on accept, keep last value after a drain
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out0 <= '0;
        end else if (accept0) begin
            out0 <= in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out1 <= '0;
        end else if (accept1) begin
            out1 <= in;
        end
    end

`ifdef DMUX16_COUNT_EN
    // ------------------------------------------------------------------
    // Per-channel accept counters, free-running wrap at 16 bits
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count0 <= '0;
        end else if (accept0) begin
            count0 <= count0 + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count1 <= '0;
        end else if (accept1) begin
            count1 <= count1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmux16_stream.sv
// ----------------------------------------------------------------------------
// tb_dmux16_stream
//
// Directed self-checking bench for dmux16_stream. Inputs are driven 1 ns
// after the rising edge and outputs sampled at the same point, well away
// from the active edge. Define DMUX16_COUNT_EN to also exercise counters.
// ----------------------------------------------------------------------------
module tb_dmux16_stream;

    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic        in_valid;
    logic        in_ready;
    logic        s;
    logic [15:0] out0;
    logic        out0_valid;
    logic        out0_ready;
    logic [15:0] out1;
    logic        out1_valid;
    logic        out1_ready;
`ifdef DMUX16_COUNT_EN
    logic [15:0] count0;
    logic [15:0] count1;
`endif

    int unsigned n_pass;
    int unsigned n_total;

    dmux16_stream #(.width(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .s          (s),
        .out0       (out0),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1       (out1),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`ifdef DMUX16_COUNT_EN
        ,
        .count0     (count0),
        .count1     (count1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in = '0; in_valid = 1'b0; s = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        step(); step();
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_during: got %b exp 1", in_ready); else n_pass++;
        reset = 1'b0;
        step();
        n_total++; if (out0 !== 16'h0000) $display("FAIL reset_out0: got %h exp 0000", out0); else n_pass++;
        n_total++; if (out1 !== 16'h0000) $display("FAIL reset_out1: got %h exp 0000", out1); else n_pass++;
        n_total++; if (out0_valid !== 1'b0) $display("FAIL reset_out0_valid: got %b exp 0", out0_valid); else n_pass++;
        n_total++; if (out1_valid !== 1'b0) $display("FAIL reset_out1_valid: got %b exp 0", out1_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", in_ready); else n_pass++;
    endtask

    task automatic test_single_and_stall();
        in = 16'h02F3; s = 1'b0; in_valid = 1'b1; out0_ready = 1'b0; out1_ready = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL single_in_ready: got %b exp 1", in_ready); else n_pass++;
        step();
        in_valid = 1'b0;
        n_total++; if (out0 !== 16'h02F3) $display("FAIL single_out0: got %h exp 02f3", out0); else n_pass++;
        n_total++; if (out0_valid !== 1'b1) $display("FAIL single_out0_valid: got %b exp 1", out0_valid); else n_pass++;
        n_total++; if (out1_valid !== 1'b0) $display("FAIL single_out1_valid: got %b exp 0", out1_valid); else n_pass++;
        // Channel 0 full and stalled: a second word must be refused.
        in = 16'hFFFF; s = 1'b0; in_valid = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b exp 0", in_ready); else n_pass++;
        step();
        n_total++; if (out0 !== 16'h02F3) $display("FAIL stall_out0_held: got %h exp 02f3", out0); else n_pass++;
        n_total++; if (out0_valid !== 1'b1) $display("FAIL stall_out0_valid: got %b exp 1", out0_valid); else n_pass++;
        out0_ready = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b exp 1", in_ready); else n_pass++;
        step();
        in_valid = 1'b0;
        n_total++; if (out0 !== 16'hFFFF) $display("FAIL b2b_out0: got %h exp ffff", out0); else n_pass++;
        n_total++; if (out0_valid !== 1'b1) $display("FAIL b2b_out0_valid: got %b exp 1", out0_valid); else n_pass++;
        step();
        n_total++; if (out0_valid !== 1'b0) $display("FAIL drain_out0_valid: got %b exp 0", out0_valid); else n_pass++;
        n_total++; if (out0 !== 16'hFFFF) $display("FAIL drain_out0_kept: got %h exp ffff", out0); else n_pass++;
        out0_ready = 1'b0;
    endtask

    task automatic test_independent_channels();
        in = 16'h02F3; s = 1'b0; in_valid = 1'b1; out0_ready = 1'b0; out1_ready = 1'b0;
        step();
        in = 16'hFFFF; s = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL indep_in_ready: got %b exp 1", in_ready); else n_pass++;
        step();
        in_valid = 1'b0;
        n_total++; if (out1 !== 16'hFFFF) $display("FAIL indep_out1: got %h exp ffff", out1); else n_pass++;
        n_total++; if (out1_valid !== 1'b1) $display("FAIL indep_out1_valid: got %b exp 1", out1_valid); else n_pass++;
        n_total++; if (out0 !== 16'h02F3) $display("FAIL indep_out0: got %h exp 02f3", out0); else n_pass++;
        n_total++; if (out0_valid !== 1'b1) $display("FAIL indep_out0_valid: got %b exp 1", out0_valid); else n_pass++;
        out0_ready = 1'b1; out1_ready = 1'b1;
        step();
        n_total++; if (out0_valid !== 1'b0) $display("FAIL indep_drain0: got %b exp 0", out0_valid); else n_pass++;
        n_total++; if (out1_valid !== 1'b0) $display("FAIL indep_drain1: got %b exp 0", out1_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            w = 16'(k);
            in = w; s = ((k % 2) == 0); in_valid = 1'b1;
            #1;
            n_total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d]: got %b exp 1", k, in_ready); else n_pass++;
            step();
            if ((k % 2) == 1) begin
                n_total++; if (out0 !== w || out0_valid !== 1'b1) $display("FAIL stream_out0[%0d]: got %h/%b exp %h/1", k, out0, out0_valid, w); else n_pass++;
                if (k > 1) begin
                    n_total++; if (out1_valid !== 1'b0) $display("FAIL stream_out1_drained[%0d]: got %b exp 0", k, out1_valid); else n_pass++;
                end
            end else begin
                n_total++; if (out1 !== w || out1_valid !== 1'b1) $display("FAIL stream_out1[%0d]: got %h/%b exp %h/1", k, out1, out1_valid, w); else n_pass++;
                n_total++; if (out0_valid !== 1'b0) $display("FAIL stream_out0_drained[%0d]: got %b exp 0", k, out0_valid); else n_pass++;
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        out0_ready = 1'b0; out1_ready = 1'b0;
        in = 16'h1234; s = 1'b0; in_valid = 1'b1;
        step();
        in = 16'hABCD; s = 1'b1;
        step();
        in_valid = 1'b0;
        n_total++; if (out0 !== 16'h1234 || out1 !== 16'hABCD) $display("FAIL areset_pre: got %h/%h exp 1234/abcd", out0, out1); else n_pass++;
        n_total++; if (out0_valid !== 1'b1 || out1_valid !== 1'b1) $display("FAIL areset_pre_valid: got %b/%b exp 1/1", out0_valid, out1_valid); else n_pass++;
        // Mid-cycle, no clock edge between assertion and sampling.
        #3 reset = 1'b1;
        #1;
        n_total++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) $display("FAIL areset_valids: got %b/%b exp 0/0", out0_valid, out1_valid); else n_pass++;
        n_total++; if (out0 !== 16'h0000 || out1 !== 16'h0000) $display("FAIL areset_data: got %h/%h exp 0000/0000", out0, out1); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL areset_in_ready: got %b exp 1", in_ready); else n_pass++;
        step();
        reset = 1'b0;
        in = 16'h02F3; s = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_total++; if (out0 !== 16'h02F3 || out0_valid !== 1'b1) $display("FAIL areset_after: got %h/%b exp 02f3/1", out0, out0_valid); else n_pass++;
        n_total++; if (out1_valid !== 1'b0) $display("FAIL areset_after_out1: got %b exp 0", out1_valid); else n_pass++;
        out0_ready = 1'b1; out1_ready = 1'b1;
        step();
    endtask

`ifdef DMUX16_COUNT_EN
    task automatic test_counters();
        reset = 1'b1;
        step();
        reset = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        in = 16'h5A5A; s = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 65534; i++) step();
        in_valid = 1'b0;
        #1;
        n_total++; if (count0 !== 16'hFFFE) $display("FAIL cnt_preload: got %h exp fffe", count0); else n_pass++;
        n_total++; if (count1 !== 16'h0000) $display("FAIL cnt_preload_c1: got %h exp 0000", count1); else n_pass++;
        in_valid = 1'b1;
        step(); step();
        in_valid = 1'b0;
        n_total++; if (count0 !== 16'h0000) $display("FAIL cnt_wrap: got %h exp 0000", count0); else n_pass++;
        n_total++; if (count1 !== 16'h0000) $display("FAIL cnt_wrap_c1: got %h exp 0000", count1); else n_pass++;
        s = 1'b1; in_valid = 1'b1;
        step();
        s = 1'b0;
        step();
        in_valid = 1'b0;
        n_total++; if (count0 !== 16'h0001 || count1 !== 16'h0001) $display("FAIL cnt_split: got %h/%h exp 0001/0001", count0, count1); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++; if (count0 !== 16'h0000 || count1 !== 16'h0000) $display("FAIL cnt_reset: got %h/%h exp 0000/0000", count0, count1); else n_pass++;
        step();
        reset = 1'b0;
    endtask
`endif

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_single_and_stall();
        test_independent_channels();
        test_back_to_back();
        test_async_reset();
`ifdef DMUX16_COUNT_EN
        test_counters();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
